// File: rtl/led_bar_meter.sv
// LED bar-graph meter: quantises an audio magnitude stream into a bar/dot display
// with fast attack, slow decay, peak-hold marker and a sweep test pattern.
module led_bar_meter #(
    parameter  int N_LEDS      = 18,
    parameter  int LVL_W       = 16,
    parameter  int TICK_DIV    = 270000,
    parameter  int DECAY_TICKS = 4,
    parameter  int HOLD_TICKS  = 50,
    localparam int SEG_W       = $clog2(N_LEDS + 1)
) (
    input  logic              clk_27,
    input  logic              reset_bar,
    input  logic [LVL_W-1:0]  level,
    input  logic              level_valid,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] led,
    output logic [SEG_W-1:0]  peak_seg,
    output logic              tick
);

    localparam int CNT_W  = $clog2(TICK_DIV);
    localparam int DEC_W  = $clog2(DECAY_TICKS + 1);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 2);
    localparam int PROD_W = LVL_W + SEG_W + 1;

    typedef enum logic [1:0] {
        MODE_BAR   = 2'b00,
        MODE_DOT   = 2'b01,
        MODE_PEAK  = 2'b10,
        MODE_SWEEP = 2'b11
    } mode_t;

    mode_t              cur_mode;
    logic [CNT_W-1:0]   tick_cnt;
    logic [SEG_W-1:0]   disp;
    logic [SEG_W-1:0]   peak;
    logic [DEC_W-1:0]   decay_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [N_LEDS-1:0]  pattern;
    logic               in_sweep;

    logic [PROD_W-1:0]  prod;
    logic [SEG_W-1:0]   seg;
    logic               attack;
    logic               sweep;
    logic [SEG_W-1:0]   disp_nxt;
    logic [SEG_W-1:0]   peak_nxt;
    logic [DEC_W-1:0]   decay_nxt;
    logic [HOLD_W-1:0]  hold_nxt;
    logic [N_LEDS-1:0]  pattern_nxt;
    logic [N_LEDS-1:0]  bar_mask;
    logic [N_LEDS-1:0]  dot_mask;
    logic [N_LEDS-1:0]  peak_mask;
    logic [N_LEDS-1:0]  led_nxt;

    assign cur_mode = mode_t'(mode);
    assign sweep    = (cur_mode == MODE_SWEEP);
    assign tick     = (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign peak_seg = peak;

    // Full-width product keeps all-ones input mapping exactly to N_LEDS.
    assign prod   = PROD_W'(level) * PROD_W'(N_LEDS + 1);
    assign seg    = SEG_W'(prod >> LVL_W);
    assign attack = level_valid && (seg > disp);

    always_comb begin
        disp_nxt  = disp;
        decay_nxt = decay_cnt;
        if (attack) begin
            disp_nxt  = seg;
            decay_nxt = '0;
        end else if (tick && (disp != '0)) begin
            if (decay_cnt == DEC_W'(DECAY_TICKS - 1)) begin
                disp_nxt  = disp - SEG_W'(1);
                decay_nxt = '0;
            end else begin
                decay_nxt = decay_cnt + DEC_W'(1);
            end
        end
    end

    // Capture beats hold countdown; the marker is never allowed below the bar.
    always_comb begin
        peak_nxt = peak;
        hold_nxt = hold_cnt;
        if (level_valid && (seg >= peak)) begin
            peak_nxt = seg;
            hold_nxt = HOLD_W'(HOLD_TICKS);
        end else if (tick) begin
            if (hold_cnt != '0) begin
                hold_nxt = hold_cnt - HOLD_W'(1);
            end else if (peak > disp) begin
                peak_nxt = peak - SEG_W'(1);
            end
        end
        if (disp_nxt > peak_nxt) begin
            peak_nxt = disp_nxt;
        end
    end

    always_comb begin
        pattern_nxt = pattern;
        if (sweep) begin
            if (!in_sweep) begin
                pattern_nxt = N_LEDS'(1);
            end else if (tick) begin
                pattern_nxt = (&pattern) ? N_LEDS'(1) : {pattern[N_LEDS-2:0], 1'b1};
            end
        end
    end

    always_comb begin
        bar_mask  = ~({N_LEDS{1'b1}} << disp);
        dot_mask  = (disp == '0) ? '0 : (N_LEDS'(1) << (disp - SEG_W'(1)));
        peak_mask = (peak == '0) ? '0 : (N_LEDS'(1) << (peak - SEG_W'(1)));
        led_nxt   = '0;
        case (cur_mode)
            MODE_BAR:   led_nxt = bar_mask;
            MODE_DOT:   led_nxt = dot_mask;
            MODE_PEAK:  led_nxt = bar_mask | peak_mask;
            MODE_SWEEP: led_nxt = pattern_nxt;
            default:    led_nxt = '0;
        endcase
    end

    always_ff @(posedge clk_27 or negedge reset_bar) begin
        if (!reset_bar) begin
            tick_cnt  <= '0;
            disp      <= '0;
            peak      <= '0;
            decay_cnt <= '0;
            hold_cnt  <= '0;
            pattern   <= N_LEDS'(1);
            in_sweep  <= 1'b0;
            led       <= '0;
        end else begin
            tick_cnt  <= tick ? '0 : tick_cnt + CNT_W'(1);
            disp      <= disp_nxt;
            peak      <= peak_nxt;
            decay_cnt <= decay_nxt;
            hold_cnt  <= hold_nxt;
            pattern   <= pattern_nxt;
            in_sweep  <= sweep;
            led       <= led_nxt;
        end
    end

endmodule

// File: tb/tb_led_bar_meter.sv
// Directed bench for led_bar_meter with small timing parameters
// (TICK_DIV=4, DECAY_TICKS=2, HOLD_TICKS=3).
module tb_led_bar_meter;

    logic        clk_27 = 1'b0;
    logic        reset_bar = 1'b0;
    logic [15:0] level = '0;
    logic        level_valid = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [17:0] led;
    logic [4:0]  peak_seg;
    logic        tick;

    int checks = 0;
    int errors = 0;
    int edge_num = 0;
    int base = 0;

    typedef struct {
        logic        valid;
        logic [15:0] lvl;
        logic [1:0]  md;
        logic [17:0] exp_led;
        logic [4:0]  exp_peak;
        logic        exp_tick;
    } vec_t;

    vec_t vecs[14];

    led_bar_meter #(
        .N_LEDS(18), .LVL_W(16), .TICK_DIV(4), .DECAY_TICKS(2), .HOLD_TICKS(3)
    ) dut (
        .clk_27(clk_27),
        .reset_bar(reset_bar),
        .level(level),
        .level_valid(level_valid),
        .mode(mode),
        .led(led),
        .peak_seg(peak_seg),
        .tick(tick)
    );

    always #5 clk_27 = ~clk_27;

    function automatic logic [17:0] barOf(input int n);
        logic [31:0] v;
        v = (32'd1 << n) - 32'd1;
        return v[17:0];
    endfunction

    function automatic logic [17:0] dotOf(input int n);
        logic [31:0] v;
        v = (n == 0) ? 32'd0 : (32'd1 << (n - 1));
        return v[17:0];
    endfunction

    task automatic applyStimulus(input logic v, input logic [15:0] l, input logic [1:0] m);
        level_valid = v;
        level       = l;
        mode        = m;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (edge %0d): got 0x%0h expected 0x%0h", name, edge_num, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_27);
            #1;
            edge_num++;
        end
    endtask

    task automatic stepTo(input int target);
        while (edge_num < target) step(1);
    endtask

    // Leaves the bench sampling a cycle with tick high, so the next edge consumes a tick.
    task automatic syncToTick();
        int budget;
        budget = 0;
        while (tick !== 1'b1 && budget < 8) begin
            step(1);
            budget++;
        end
        checkOutput("sync_tick", {31'd0, tick}, 32'd1);
    endtask

    task automatic checkLedPeak(input string name, input int n, input logic [17:0] el, input logic [4:0] ep);
        stepTo(base + n);
        checkOutput({name, "_led"}, {14'd0, led}, {14'd0, el});
        checkOutput({name, "_peak"}, {27'd0, peak_seg}, {27'd0, ep});
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 12; i++) begin
            vecs[i] = '{1'b0, 16'h0000, 2'b00, 18'h0, 5'd0, ((i + 1) % 4) == 3};
        end
        vecs[12] = '{1'b1, 16'hFFFF, 2'b00, 18'h00000, 5'd18, 1'b0};
        vecs[13] = '{1'b0, 16'h0000, 2'b00, 18'h3FFFF, 5'd18, 1'b0};

        // Reset holds everything cleared even with a full-scale valid sample present.
        applyStimulus(1'b1, 16'hFFFF, 2'b00);
        step(3);
        checkOutput("reset_led", {14'd0, led}, 32'd0);
        checkOutput("reset_peak", {27'd0, peak_seg}, 32'd0);
        checkOutput("reset_tick", {31'd0, tick}, 32'd0);
        reset_bar = 1'b1;
        edge_num = 0;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].lvl, vecs[i].md);
            step(1);
            checkOutput($sformatf("vec%0d_led", i), {14'd0, led}, {14'd0, vecs[i].exp_led});
            checkOutput($sformatf("vec%0d_peak", i), {27'd0, peak_seg}, {27'd0, vecs[i].exp_peak});
            checkOutput($sformatf("vec%0d_tick", i), {31'd0, tick}, {31'd0, vecs[i].exp_tick});
        end

        // Bar decays one segment every 8 cycles, first drop visible at edge 21.
        for (int m = 0; m < 18; m++) begin
            stepTo(20 + 8 * m);
            checkOutput($sformatf("decay_pre%0d", m), {14'd0, led}, {14'd0, barOf(18 - m)});
            step(1);
            checkOutput($sformatf("decay_post%0d", m), {14'd0, led}, {14'd0, barOf(17 - m)});
        end
        stepTo(173);
        checkOutput("decay_floor_led", {14'd0, led}, 32'd0);
        checkOutput("decay_floor_peak", {27'd0, peak_seg}, 32'd0);

        // Bar + peak marker with hold then fall.
        syncToTick();
        base = edge_num + 1;
        applyStimulus(1'b1, 16'h8000, 2'b10);
        step(1);
        applyStimulus(1'b1, 16'h0000, 2'b10);
        step(1);
        applyStimulus(1'b0, 16'h0000, 2'b10);
        checkLedPeak("pk1", 1, 18'h001FF, 5'd9);
        checkLedPeak("pk9", 9, 18'h001FF, 5'd9);
        checkLedPeak("pk15", 15, 18'h001FF, 5'd9);
        checkLedPeak("pk16", 16, 18'h001FF, 5'd8);
        checkLedPeak("pk17", 17, 18'h000FF, 5'd8);
        checkLedPeak("pk20", 20, 18'h000FF, 5'd7);
        checkLedPeak("pk21", 21, 18'h0007F, 5'd7);
        checkLedPeak("pk25", 25, 18'h0007F, 5'd7);
        checkLedPeak("pk28", 28, 18'h0007F, 5'd6);
        checkLedPeak("pk29", 29, 18'h0003F, 5'd6);
        checkLedPeak("pk80", 80, 18'h00000, 5'd0);

        // Dot mode, small level then a sub-threshold-ish sample while decaying.
        syncToTick();
        base = edge_num + 1;
        applyStimulus(1'b1, 16'h1000, 2'b01);
        step(1);
        applyStimulus(1'b1, 16'h0F00, 2'b01);
        step(1);
        applyStimulus(1'b0, 16'h0000, 2'b01);
        checkLedPeak("dot1", 1, 18'h00001, 5'd1);
        checkLedPeak("dot8", 8, 18'h00001, 5'd1);
        checkLedPeak("dot9", 9, 18'h00000, 5'd1);
        checkLedPeak("dot15", 15, 18'h00000, 5'd1);
        checkLedPeak("dot16", 16, 18'h00000, 5'd0);

        // Attack landing on the same edge as a decay step and a hold decrement.
        syncToTick();
        base = edge_num + 1;
        applyStimulus(1'b1, 16'h8000, 2'b01);
        step(1);
        applyStimulus(1'b0, 16'h0000, 2'b01);
        checkLedPeak("coin1", 1, dotOf(9), 5'd9);
        stepTo(base + 7);
        applyStimulus(1'b1, 16'hC000, 2'b01);
        step(1);
        applyStimulus(1'b0, 16'h0000, 2'b01);
        checkLedPeak("coin8", 8, dotOf(9), 5'd14);
        checkLedPeak("coin9", 9, dotOf(14), 5'd14);
        checkLedPeak("coin16", 16, dotOf(14), 5'd14);
        checkLedPeak("coin17", 17, dotOf(13), 5'd14);
        checkLedPeak("coin23", 23, dotOf(13), 5'd14);
        checkLedPeak("coin24", 24, dotOf(13), 5'd13);

        // Sweep: entry shows one LED, each tick fills one more, all-ones wraps to one.
        syncToTick();
        base = edge_num + 1;
        applyStimulus(1'b0, 16'h0000, 2'b11);
        step(1);
        checkOutput("sweep_entry", {14'd0, led}, 32'h1);
        for (int m = 1; m <= 18; m++) begin
            stepTo(base + 4 * m - 1);
            checkOutput($sformatf("sweep_hold%0d", m), {14'd0, led}, {14'd0, barOf(m)});
            step(1);
            checkOutput($sformatf("sweep_step%0d", m), {14'd0, led},
                        {14'd0, (m < 18) ? barOf(m + 1) : 18'h00001});
        end
        step(2);
        #2;
        reset_bar = 1'b0;
        #1;
        checkOutput("midreset_led", {14'd0, led}, 32'd0);
        checkOutput("midreset_peak", {27'd0, peak_seg}, 32'd0);
        checkOutput("midreset_tick", {31'd0, tick}, 32'd0);

        @(posedge clk_27);
        #1;
        applyStimulus(1'b0, 16'h0000, 2'b00);
        reset_bar = 1'b1;
        edge_num = 0;
        for (int k = 1; k <= 4; k++) begin
            step(1);
            checkOutput($sformatf("post_reset_tick%0d", k), {31'd0, tick}, {31'd0, k == 3});
        end
        checkOutput("post_reset_led", {14'd0, led}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
